led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent LED channels (1..16).
REQ-002 SHALL have parameter PRESC_W, default 24, width of per-channel period counter.
REQ-003 SHALL have parameter PWM_W, default 8, width of PWM counter and duty/brightness values.
REQ-004 SHALL have parameter PERIOD_DEF, default 24'hFFFFF, per-channel period loaded at reset.
REQ-005 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-007 SHALL have port cfg_we_i  input  1  configuration write strobe, one cycle per write.
REQ-008 SHALL have port cfg_ch_i  input  4  target channel index for the write.
REQ-009 SHALL have port cfg_mode_i  input  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
REQ-010 SHALL have port cfg_period_i  input  PRESC_W  period value for the write.
REQ-011 SHALL have port cfg_duty_i  input  PWM_W  duty value for the write (used in ON mode as PWM duty).
REQ-012 SHALL have port led_o  output  N_CH  registered LED drive, one bit per channel.

Function
REQ-013 SHALL keep per channel registers mode, period, duty, cnt (PRESC_W), level (1), bright (PWM_W), dir (UP/DOWN).
REQ-014 SHALL run one shared free-running pwm_cnt (PWM_W), incrementing every cycle, wrapping all-ones -> 0.
REQ-015 On cfg_we_i=1 with cfg_ch_i < N_CH, SHALL load mode/period/duty of that channel and clear its cnt, level, bright to 0 and set dir UP on the same edge.
REQ-016 On cfg_we_i=1 with cfg_ch_i >= N_CH, SHALL change no state.
REQ-017 A write SHALL take priority over any simultaneous counter wrap or brightness step on that channel.
REQ-018 In OFF, led_o[k] SHALL be 0; cnt held at 0.
REQ-019 In ON, led_o[k] SHALL be registered (pwm_cnt < duty); duty 0 -> never high, duty all-ones -> high (2^PWM_W-1) of every 2^PWM_W cycles.
REQ-020 In BLINK, cnt SHALL increment each cycle; on the edge where cnt==period, cnt -> 0 and level toggles; led_o[k]=level, so half-period = period+1 cycles; period 0 toggles every cycle.
REQ-021 In BREATHE, cnt SHALL wrap as in BLINK; on each wrap bright steps +1 (UP) or -1 (DOWN).
REQ-022 BREATHE FSM: UP -> DOWN on the step reaching all-ones; DOWN -> UP on the step reaching 0; bright never wraps.
REQ-023 In BREATHE, led_o[k] SHALL be registered (pwm_cnt < bright).
REQ-024 Channels SHALL be fully independent except for the shared pwm_cnt.

Reset
REQ-025 While reset_i=1 at a rising edge: every channel mode=BLINK, period=PERIOD_DEF, duty=0, cnt=0, level=0, bright=0, dir=UP; pwm_cnt=0; led_o=0.
REQ-026 Reset SHALL override any simultaneous cfg_we_i; reset mid-pattern SHALL return to the REQ-025 state in one edge.

Structure
REQ-027 Mode encodings (OFF/ON/BLINK/BREATHE) and dir encoding SHALL live in shared package led_pattern_pkg.
REQ-028 Per-channel logic SHALL be sub-module led_pattern_ch, instantiated N_CH times by generate; pwm_cnt and write decode stay in the top.

Verification (N_CH=4, PRESC_W=8, PWM_W=4, PERIOD_DEF=3)
REQ-029 Release reset, no writes -> all led_o rise on 4th edge after release, toggle every 4 cycles thereafter (8-cycle period).
REQ-030 Write ch1 ON duty=5 -> led_o[1] high exactly 5 of every 16 cycles; rewrite duty=0 -> led_o[1] constant 0.
REQ-031 Write ch2 BREATHE period=15 -> per-16-cycle high count ramps 0,1..15,14..1,0 (30 steps = 480 cycles), then repeats.
REQ-032 Write ch3 BLINK period=1 while led_o[3]=1 -> led_o[3]=0 next edge, then toggles every 2 cycles; other channels undisturbed.
REQ-033 Write cfg_ch_i=5, and separately cfg_we_i coincident with reset_i -> no state change / reset state respectively.
REQ-034 Assert reset_i mid-BREATHE on ch2 -> next edge all led_o=0 and ch2 back to BLINK period 3.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern generator: channel modes, the
// breathe direction state, and the width of the channel-select field.
package led_pattern_pkg;

    // Channel operating modes, encoded exactly as driven on cfg_mode_i.
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    // Breathe ramp direction; doubles as the state of the per-channel breathe FSM.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Width of the channel index on the configuration port.
    localparam int CH_IDX_W = 4;

    // Maps a channel's post-edge state to its LED drive. The PWM modes
    // compare against the shared counter value seen at the same edge.
    function automatic logic led_drive(
        input mode_e mode,
        input logic  pwm_lt_duty,
        input logic  pwm_lt_bright,
        input logic  level
    );
        logic drive;
        drive = 1'b0;
        case (mode)
            MODE_OFF:     drive = 1'b0;
            MODE_ON:      drive = pwm_lt_duty;
            MODE_BLINK:   drive = level;
            MODE_BREATHE: drive = pwm_lt_bright;
            default:      drive = 1'b0;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/led_pattern_ch.sv
// One independent LED channel: holds its own configuration, period
// counter, blink level and breathe brightness, and registers its LED bit.
module led_pattern_ch
    import led_pattern_pkg::*;
#(
    parameter int          PRESC_W    = 24,
    parameter int          PWM_W      = 8,
    parameter int unsigned PERIOD_DEF = 24'hFFFFF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               wr_i,
    input  mode_e              mode_i,
    input  logic [PRESC_W-1:0] period_i,
    input  logic [PWM_W-1:0]   duty_i,
    input  logic [PWM_W-1:0]   pwm_cnt_i,
    output logic               led_o
);

    localparam logic [PRESC_W-1:0] PERIOD_RST = PRESC_W'(PERIOD_DEF);
    localparam logic [PWM_W-1:0]   BRIGHT_MAX = '1;

    mode_e              mode_q,   mode_d;
    logic [PRESC_W-1:0] period_q, period_d;
    logic [PWM_W-1:0]   duty_q,   duty_d;
    logic [PRESC_W-1:0] cnt_q,    cnt_d;
    logic               level_q,  level_d;
    logic [PWM_W-1:0]   bright_q, bright_d;
    dir_e               dir_q,    dir_d;
    logic               led_q,    led_d;
    logic               wrap;

    assign wrap  = (cnt_q == period_q);
    assign led_o = led_q;

    // Next-state logic: a configuration write wins over any counter wrap or
    // brightness step on the same edge; otherwise the current mode advances.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch;
        // blocking '=' is correct here because this is combinational logic.
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        bright_d = bright_q;
        dir_d    = dir_q;

        if (wr_i) begin
            mode_d   = mode_i;
            period_d = period_i;
            duty_d   = duty_i;
            cnt_d    = '0;
            level_d  = 1'b0;
            bright_d = '0;
            dir_d    = DIR_UP;
        end else begin
            case (mode_q)
                MODE_OFF: begin
                    cnt_d = '0;
                end
                MODE_ON: begin
                    cnt_d = cnt_q;
                end
                MODE_BLINK: begin
                    if (wrap) begin
                        cnt_d   = '0;
                        level_d = ~level_q;
                    end else begin
                        cnt_d = cnt_q + PRESC_W'(1);
                    end
                end
                MODE_BREATHE: begin
                    if (wrap) begin
                        cnt_d = '0;
                        // Brightness turns around at the rails instead of wrapping.
                        if (dir_q == DIR_UP) begin
                            bright_d = bright_q + PWM_W'(1);
                            if (bright_d == BRIGHT_MAX) dir_d = DIR_DOWN;
                        end else begin
                            bright_d = bright_q - PWM_W'(1);
                            if (bright_d == '0) dir_d = DIR_UP;
                        end
                    end else begin
                        cnt_d = cnt_q + PRESC_W'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end

        led_d = led_drive(mode_d, (pwm_cnt_i < duty_d), (pwm_cnt_i < bright_d), level_d);
    end

    // Channel state register with synchronous reset to a default slow blink.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block
        // and never appears in the sensitivity list; state uses '<=' only.
        if (reset_i) begin
            mode_q   <= MODE_BLINK;
            period_q <= PERIOD_RST;
            duty_q   <= '0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            bright_q <= '0;
            dir_q    <= DIR_UP;
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            bright_q <= bright_d;
            dir_q    <= dir_d;
            led_q    <= led_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a shared free-running PWM counter,
// write decode for the configuration port, and N_CH independent channels.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int          N_CH       = 4,
    parameter int          PRESC_W    = 24,
    parameter int          PWM_W      = 8,
    parameter int unsigned PERIOD_DEF = 24'hFFFFF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                cfg_we_i,
    input  logic [CH_IDX_W-1:0] cfg_ch_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [PRESC_W-1:0]  cfg_period_i,
    input  logic [PWM_W-1:0]    cfg_duty_i,
    output logic [N_CH-1:0]     led_o
);

    logic [PWM_W-1:0] pwm_cnt;
    logic [N_CH-1:0]  ch_wr;
    mode_e            cfg_mode;

    assign cfg_mode = mode_e'(cfg_mode_i);

    // Shared PWM time base, wrapping naturally from all-ones to zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // One-hot write decode; an index at or beyond N_CH selects no channel.
    always_comb begin
        ch_wr = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_wr[k] = cfg_we_i && (cfg_ch_i == CH_IDX_W'(k));
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        led_pattern_ch #(
            .PRESC_W    (PRESC_W),
            .PWM_W      (PWM_W),
            .PERIOD_DEF (PERIOD_DEF)
        ) u_ch (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .wr_i      (ch_wr[k]),
            .mode_i    (cfg_mode),
            .period_i  (cfg_period_i),
            .duty_i    (cfg_duty_i),
            .pwm_cnt_i (pwm_cnt),
            .led_o     (led_o[k])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen. The reference model tracks, per
// channel, only the written configuration and the number of edges since that
// write; the LED value is derived in closed form from those.
module tb_led_pattern_gen;

    localparam int N_CH       = 4;
    localparam int PRESC_W    = 8;
    localparam int PWM_W      = 4;
    localparam int PERIOD_DEF = 3;
    localparam int PWM_MOD    = 1 << PWM_W;
    localparam int BR_MAX     = PWM_MOD - 1;

    logic               clk_i = 1'b0;
    logic               reset_i;
    logic               cfg_we_i;
    logic [3:0]         cfg_ch_i;
    logic [1:0]         cfg_mode_i;
    logic [PRESC_W-1:0] cfg_period_i;
    logic [PWM_W-1:0]   cfg_duty_i;
    logic [N_CH-1:0]    led_o;

    led_pattern_gen #(
        .N_CH       (N_CH),
        .PRESC_W    (PRESC_W),
        .PWM_W      (PWM_W),
        .PERIOD_DEF (PERIOD_DEF)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_ch_i     (cfg_ch_i),
        .cfg_mode_i   (cfg_mode_i),
        .cfg_period_i (cfg_period_i),
        .cfg_duty_i   (cfg_duty_i),
        .led_o        (led_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state.
    int m_mode   [N_CH];
    int m_period [N_CH];
    int m_duty   [N_CH];
    int m_t      [N_CH];
    int m_pwm;

    logic [N_CH-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // Breathe brightness after s steps: triangle 0..max..0 with period 2*max.
    function automatic int tri_bright(input int s);
        int ph;
        ph = s % (2 * BR_MAX);
        return (ph <= BR_MAX) ? ph : (2 * BR_MAX - ph);
    endfunction

    function automatic logic model_led(input int k, input int pwm_seen);
        int steps;
        steps = m_t[k] / (m_period[k] + 1);
        case (m_mode[k])
            0:       return 1'b0;
            1:       return pwm_seen < m_duty[k];
            2:       return (steps % 2) == 1;
            default: return pwm_seen < tri_bright(steps);
        endcase
    endfunction

    // Apply one cycle of inputs, advance the model across the coming edge,
    // queue the expected LED vector, then move to just after the next negedge.
    task automatic step(input logic rst, input logic we, input int ch,
                        input int mode, input int period, input int duty);
        logic [N_CH-1:0] e;
        int pwm_seen;
        reset_i      = rst;
        cfg_we_i     = we;
        cfg_ch_i     = 4'(ch);
        cfg_mode_i   = 2'(mode);
        cfg_period_i = PRESC_W'(period);
        cfg_duty_i   = PWM_W'(duty);

        pwm_seen = m_pwm;
        e = '0;
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                m_mode[k] = 2; m_period[k] = PERIOD_DEF; m_duty[k] = 0; m_t[k] = 0;
            end
            m_pwm = 0;
        end else begin
            m_pwm = (m_pwm + 1) % PWM_MOD;
            for (int k = 0; k < N_CH; k++) begin
                if (we && ch == k) begin
                    m_mode[k] = mode; m_period[k] = period; m_duty[k] = duty; m_t[k] = 0;
                end else begin
                    m_t[k] = m_t[k] + 1;
                end
                e[k] = model_led(k, pwm_seen);
            end
        end
        exp_q.push_back(e);
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    // Monitor: the LED vector is valid every cycle; compare one entry per negedge.
    initial begin
        logic [N_CH-1:0] want;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                vectors++;
                if (led_o !== want) begin
                    miscompares++;
                    $display("FAIL led_o vec %0d t=%0t: got %b want %b", vectors, $time, led_o, want);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N_CH; k++) begin
            m_mode[k] = 2; m_period[k] = PERIOD_DEF; m_duty[k] = 0; m_t[k] = 0;
        end
        m_pwm = 0;

        // Reset, then free-running default blink on every channel.
        step(1'b1, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0, 0);
        idle(24);

        // ch1 ON: duty 5, then duty 0, then full-scale duty.
        step(1'b0, 1'b1, 1, 1, 0, 5);
        idle(48);
        step(1'b0, 1'b1, 1, 1, 0, 0);
        idle(32);
        step(1'b0, 1'b1, 1, 1, 0, BR_MAX);
        idle(32);

        // ch2 BREATHE period 15: more than one full ramp up and down.
        step(1'b0, 1'b1, 2, 3, 15, 0);
        idle(1000);

        // ch3 BLINK period 1, issued while its LED is high.
        while (!led_o[3]) idle(1);
        step(1'b0, 1'b1, 3, 2, 1, 0);
        idle(20);

        // Out-of-range channel, write coincident with reset, OFF mode, period 0.
        step(1'b0, 1'b1, 5, 0, 0, 0);
        idle(10);
        step(1'b1, 1'b1, 0, 1, 7, 9);
        idle(10);
        step(1'b0, 1'b1, 0, 0, 0, 0);
        step(1'b0, 1'b1, 1, 2, 0, 0);
        step(1'b0, 1'b1, 2, 3, 0, 0);
        idle(80);

        // Reset in the middle of a breathe ramp.
        step(1'b0, 1'b1, 2, 3, 2, 0);
        idle(100);
        step(1'b1, 1'b0, 0, 0, 0, 0);
        idle(20);

        // Randomized traffic: sparse writes, some invalid channels, rare resets.
        for (int i = 0; i < 5000; i++) begin
            int r;
            int per;
            r   = int'($urandom_range(0, 999));
            per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 5));
            step(r < 3, (r >= 3 && r < 50) || r == 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 per, int'($urandom_range(0, BR_MAX)));
        end

        @(negedge clk_i);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
